fft16_frame_ctrl: RTL and testbench
===================================

Name: fft16_frame_ctrl

Overview:
Frame sequencer for the 16-point radix-4 FFT datapath. It accepts one frame of real samples over a valid/ready stream and writes them into the input buffer. It then issues the stage-1 and stage-2 start strobes, waiting a fixed latency after each, and streams the 16 output bins to a downstream consumer. A new frame is accepted only after the current frame has been fully unloaded; the block does not overlap frames.

Parameters:
N, 16, points per frame; fixed at 16 for this datapath.
ADDRW, 4, address and index width; equals log2(N).
WIDTH, 16, input sample width (signed, real part only).
S1_LAT, 2, stage-1 settle cycles; must be at least 1.
S2_LAT, 2, stage-2 settle cycles; must be at least 1.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort; returns the block to LOAD
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_data  in  WIDTH  signed real sample
buf_we  out  1  input-buffer write enable (maps to load)
buf_addr  out  ADDRW  input-buffer write address (maps to addr_in)
buf_wdata  out  WIDTH  input-buffer write data (maps to xr_in)
s1_start  out  1  one-cycle stage-1 start strobe
s2_start  out  1  one-cycle stage-2 start strobe
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts the bin
out_index  out  ADDRW  bin index k; drives the output select mux
out_last  out  1  high with bin N-1
frame_done  out  1  one-cycle pulse after the last bin handshake
busy  out  1  high in any state other than LOAD
frame_cnt  out  8  completed frames, wraps 255 -> 0

Behaviour:
- States: LOAD, S1, S2, UNLOAD. Counters: wr_cnt (ADDRW bits), lat_cnt (at least 8 bits), rd_cnt (ADDRW bits).
- Reset (async, rst high):
  - state=LOAD; all counters 0.
  - s1_start, s2_start, out_valid, frame_done = 0; frame_cnt = 0.
  - in_ready is forced 0 while rst is high.
- LOAD:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready.
  - Input-buffer drive is combinational: buf_we = accept, buf_addr = wr_cnt, buf_wdata = in_data. The write lands on the same edge as the accept.
  - wr_cnt increments on each accept.
  - Accept while wr_cnt==N-1: wr_cnt wraps to 0, next state S1, and s1_start is registered high for the first S1 cycle.
- S1:
  - Lasts exactly S1_LAT cycles; lat_cnt counts 0..S1_LAT-1.
  - On the final cycle: go to S2 and register s2_start high for the first S2 cycle.
- S2:
  - Lasts exactly S2_LAT cycles.
  - Then go to UNLOAD with out_valid=1 and rd_cnt=0.
- UNLOAD:
  - out_valid=1; out_index=rd_cnt; out_last=(rd_cnt==N-1).
  - On out_valid && out_ready, rd_cnt increments.
  - Handshake while out_last: state=LOAD, out_valid=0 next cycle, frame_done pulses one cycle, frame_cnt increments.
  - out_valid stays high and out_index stays stable while out_ready is low; backpressure may last indefinitely.
- Latency: the first out_valid is seen in the cycle starting S1_LAT+S2_LAT edges after the 16th accept edge (4 with defaults). Minimum frame period is N+S1_LAT+S2_LAT+N cycles (36 with defaults).
- in_ready=0 in S1, S2 and UNLOAD; in_valid is ignored there and no write occurs.
- flush:
  - Synchronous; priority below rst, above all other behaviour.
  - Next cycle: state=LOAD, counters 0, out_valid/s1_start/s2_start = 0.
  - No frame_done pulse; frame_cnt unchanged.
  - In LOAD, flush suppresses buf_we in the same cycle.
- busy = (state != LOAD).
- Reset asserted mid-frame discards the partial frame immediately. The buffer contents are not cleared.

Test Plan:
- Load samples 0..15 with in_valid held high, out_ready=1 -> buf_addr 0..15 with buf_we on 16 consecutive cycles; s1_start 1 cycle after the last accept; s2_start 2 cycles later; out_valid 4 cycles after the last accept; out_index 0..15; out_last with 15; frame_done pulses once; frame_cnt=1.
- Random in_valid gaps (about 50%) -> writes occur only on accept cycles; addresses stay contiguous 0..15; s1_start fires exactly once per frame.
- out_ready low for 5 cycles at bin 7 -> out_index holds 7 with out_valid high; resumes to 8 after the handshake; no bin skipped or repeated.
- In UNLOAD, drive in_valid=1 -> in_ready=0 and buf_we=0 throughout; after the bin-15 handshake, in_ready=1 and the next frame starts at buf_addr 0.
- flush asserted after 9 accepts, then a full 16-sample frame -> no s1_start until the 16th new accept; addresses restart at 0; frame_cnt unchanged by the flush.
- Async rst pulse mid-S2 (not edge-aligned) -> outputs go to reset values immediately; in_ready=0 during rst and 1 on the first cycle after release; 256 complete frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/fft16_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft16_frame_ctrl_if
// Brief    : Sample-in / buffer-write / bin-out bundle for the FFT16 sequencer.
// Revision : 1.0
// ============================================================================
interface fft16_frame_ctrl_if #(
    parameter int ADDRW = 4,
    parameter int WIDTH = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              buf_we;
    logic [ADDRW-1:0]  buf_addr;
    logic [WIDTH-1:0]  buf_wdata;
    logic              s1_start;
    logic              s2_start;
    logic              out_valid;
    logic              out_ready;
    logic [ADDRW-1:0]  out_index;
    logic              out_last;
    logic              frame_done;
    logic              busy;
    logic [7:0]        frame_cnt;

    // Controller side.
    modport master (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, buf_we, buf_addr, buf_wdata, s1_start, s2_start,
               out_valid, out_index, out_last, frame_done, busy, frame_cnt
    );

    // Source / sink / FFT datapath side.
    modport slave (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, buf_we, buf_addr, buf_wdata, s1_start, s2_start,
               out_valid, out_index, out_last, frame_done, busy, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fft16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft16_frame_ctrl
// Brief    : Loads a 16-sample frame, strobes both FFT stages, unloads 16 bins.
// Revision : 1.0
// ============================================================================
module fft16_frame_ctrl #(
    parameter int N      = 16,
    parameter int ADDRW  = 4,
    parameter int WIDTH  = 16,
    parameter int S1_LAT = 2,
    parameter int S2_LAT = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fft16_frame_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_S1     = 2'd1,
        ST_S2     = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    localparam logic [ADDRW-1:0] c_LAST   = ADDRW'(N - 1);
    localparam logic [7:0]       c_S1_END = 8'(S1_LAT - 1);
    localparam logic [7:0]       c_S2_END = 8'(S2_LAT - 1);

    state_t             r_state;
    logic [ADDRW-1:0]   r_wr_cnt;
    logic [7:0]         r_lat_cnt;
    logic [ADDRW-1:0]   r_rd_cnt;
    logic               r_s1_start;
    logic               r_s2_start;
    logic               r_out_valid;
    logic               r_frame_done;
    logic [7:0]         r_frame_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH-1:0]   w_wdata;

    // in_ready drops combinationally with rst so no sample is taken during reset.
    assign w_in_ready = (r_state == ST_LOAD) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_wdata    = bus.in_data;

    assign bus.in_ready   = w_in_ready;
    assign bus.buf_we     = w_accept && !bus.flush;
    assign bus.buf_addr   = r_wr_cnt;
    assign bus.buf_wdata  = w_wdata;
    assign bus.s1_start   = r_s1_start;
    assign bus.s2_start   = r_s2_start;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_index  = r_rd_cnt;
    assign bus.out_last   = r_out_valid && (r_rd_cnt == c_LAST);
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_state != ST_LOAD);
    assign bus.frame_cnt  = r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_wr_cnt     <= '0;
            r_lat_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_s1_start   <= 1'b0;
            r_s2_start   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_s1_start   <= 1'b0;
            r_s2_start   <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.flush) begin
                r_state     <= ST_LOAD;
                r_wr_cnt    <= '0;
                r_lat_cnt   <= '0;
                r_rd_cnt    <= '0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            if (r_wr_cnt == c_LAST) begin
                                r_wr_cnt   <= '0;
                                r_lat_cnt  <= '0;
                                r_s1_start <= 1'b1;
                                r_state    <= ST_S1;
                            end else begin
                                r_wr_cnt <= r_wr_cnt + 1'b1;
                            end
                        end
                    end
                    ST_S1: begin
                        if (r_lat_cnt == c_S1_END) begin
                            r_lat_cnt  <= '0;
                            r_s2_start <= 1'b1;
                            r_state    <= ST_S2;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 8'd1;
                        end
                    end
                    ST_S2: begin
                        if (r_lat_cnt == c_S2_END) begin
                            r_lat_cnt   <= '0;
                            r_rd_cnt    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_UNLOAD;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 8'd1;
                        end
                    end
                    ST_UNLOAD: begin
                        if (r_out_valid && bus.out_ready) begin
                            // rd_cnt wraps to 0 on the last bin, ready for the next frame.
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                            if (r_rd_cnt == c_LAST) begin
                                r_out_valid  <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 8'd1;
                                r_state      <= ST_LOAD;
                            end
                        end
                    end
                    default: r_state <= ST_LOAD;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fft16_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft16_frame_ctrl
// Brief    : Randomised directed bench with an elapsed-time reference model.
// Revision : 1.0
// ============================================================================
module tb_fft16_frame_ctrl;
    localparam int N      = 16;
    localparam int S1_LAT = 2;
    localparam int S2_LAT = 2;
    localparam int T_S2   = 1 + S1_LAT;
    localparam int T_UNL  = 1 + S1_LAT + S2_LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft16_frame_ctrl_if #(.ADDRW(4), .WIDTH(16)) bus ();

    fft16_frame_ctrl #(
        .N(N), .ADDRW(4), .WIDTH(16), .S1_LAT(S1_LAT), .S2_LAT(S2_LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: m_t is 0 while loading, else edges elapsed since the 16th accept.
    int m_acc    = 0;
    int m_t      = 0;
    int m_bin    = 0;
    int m_frames = 0;
    bit m_done   = 1'b0;
    int s1_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_t = 0; m_bin = 0; m_frames = 0; m_done = 1'b0;
    endtask

    task automatic check_all();
        bit ld;
        bit un;
        ld = (m_t == 0);
        un = (m_t >= T_UNL);
        chk("in_ready",   bus.in_ready,   ld && !rst);
        chk("buf_we",     bus.buf_we,     ld && !rst && bus.in_valid && !bus.flush);
        chk("buf_addr",   bus.buf_addr,   ld ? m_acc : 0);
        chk("buf_wdata",  bus.buf_wdata,  bus.in_data);
        chk("s1_start",   bus.s1_start,   m_t == 1);
        chk("s2_start",   bus.s2_start,   m_t == T_S2);
        chk("out_valid",  bus.out_valid,  un);
        chk("out_index",  bus.out_index,  un ? m_bin : 0);
        chk("out_last",   bus.out_last,   un && (m_bin == N - 1));
        chk("frame_done", bus.frame_done, m_done);
        chk("busy",       bus.busy,       !ld);
        chk("frame_cnt",  bus.frame_cnt,  m_frames & 255);
    endtask

    task automatic model_update();
        bit un;
        un = (m_t >= T_UNL);
        m_done = 1'b0;
        if (bus.flush) begin
            m_t = 0; m_acc = 0; m_bin = 0;
        end else if (m_t == 0) begin
            if (bus.in_valid) begin
                if (m_acc == N - 1) begin
                    m_acc = 0; m_t = 1;
                end else begin
                    m_acc++;
                end
            end
        end else if (!un) begin
            m_t++;
        end else if (bus.out_ready) begin
            if (m_bin == N - 1) begin
                m_bin = 0; m_t = 0; m_done = 1'b1; m_frames++;
            end else begin
                m_bin++;
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input bit v, input bit r, input bit f, input logic [15:0] d);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #2;
        check_all();
        if (bus.s1_start) s1_seen++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_frame(input int pv, input int pr);
        int start;
        int budget;
        start   = m_frames;
        budget  = 0;
        s1_seen = 0;
        while (m_frames == start && budget < 3000) begin
            cycle($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, 1'b0, 16'($urandom));
            budget++;
        end
        chk("frame_complete_cnt", bus.frame_cnt, (start + 1) & 255);
        chk("s1_once", s1_seen, 1);
    endtask

    initial begin
        int budget;
        int cnt_before;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b0;
        #1 chk("in_ready_post_rst", bus.in_ready, 1);
        @(posedge clk); #1;

        // Streaming frame with sample value equal to its index
        s1_seen = 0;
        for (int i = 0; i < N; i++) cycle(1'b1, 1'b1, 1'b0, 16'(i));
        budget = 0;
        while (m_frames == 0 && budget < 100) begin
            cycle(1'b0, 1'b1, 1'b0, 16'($urandom));
            budget++;
        end
        chk("frame1_cnt", bus.frame_cnt, 1);
        chk("frame1_s1", s1_seen, 1);

        // Random input gaps and output backpressure
        repeat (3) run_frame(50, 70);

        // Backpressure held at bin 7
        budget = 0;
        while (!(m_t >= T_UNL && m_bin == 7) && budget < 200) begin
            cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
            budget++;
        end
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 16'($urandom));
        #1;
        chk("bp_hold_idx", bus.out_index, 7);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_in_ready", bus.in_ready, 0);
        cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
        chk("bp_resume_idx", bus.out_index, 8);
        cnt_before = m_frames;
        budget = 0;
        while (m_frames == cnt_before && budget < 100) begin
            cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
            budget++;
        end
        chk("bp_frame_cnt", bus.frame_cnt, (cnt_before + 1) & 255);

        // Flush after 9 accepts, then a full frame
        budget = 0;
        while (m_acc != 9 && budget < 200) begin
            cycle($urandom_range(0, 1) == 1, 1'b1, 1'b0, 16'($urandom));
            budget++;
        end
        cnt_before = m_frames;
        cycle(1'b1, 1'b1, 1'b1, 16'($urandom));
        chk("flush_addr0", bus.buf_addr, 0);
        chk("flush_cnt_same", bus.frame_cnt, cnt_before & 255);
        run_frame(60, 100);

        // Async reset in the middle of stage 2
        budget = 0;
        while (m_t != T_S2 + 1 && budget < 200) begin
            cycle(1'b1, 1'b1, 1'b0, 16'($urandom));
            budget++;
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        check_all();
        #2 rst = 1'b0;
        #1 chk("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk); #1;

        // 256 frames to wrap the frame counter
        repeat (256) run_frame(100, 100);
        #1 chk("frame_cnt_wrap", bus.frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
